multi_button_debounce: RTL
==========================

# multi_button_debounce

Parametrised N-channel button conditioner. It replaces per-button single-pulse debouncers on the board front-end. Each channel gets a two-flop synchroniser, polarity normalisation, an integrating debounce filter, press/release edge pulses, a long-press event and optional auto-repeat. Outputs feed the calculator's input FSM directly as single-cycle strobes.

## Interface
- N_BTN, 5: number of independent channels (1..16)
- DEBOUNCE_CYCLES, 1_000_000: consecutive disagreeing cycles required to accept a new level (10 ms at 100 MHz); >= 2
- LONG_CYCLES, 100_000_000: continuous accepted-pressed cycles before long_pulse (1 s); >= 2
- REPEAT_CYCLES, 20_000_000: auto-repeat period after long press (200 ms); >= 2
- ACTIVE_LOW_MASK, {N_BTN{1'b0}}: bit i = 1 means raw btn_in[i] is low when pressed
- clk  in  1  system clock, single domain
- rst_n  in  1  asynchronous active-low reset; all state and outputs clear immediately
- btn_in  in  N_BTN  raw asynchronous button pins
- repeat_en  in  N_BTN  per-channel auto-repeat enable, sampled each cycle
- btn_level  out  N_BTN  debounced level, 1 = pressed (after polarity)
- press_pulse  out  N_BTN  1-cycle strobe on accepted 0->1
- release_pulse  out  N_BTN  1-cycle strobe on accepted 1->0
- long_pulse  out  N_BTN  1-cycle strobe when held LONG_CYCLES
- repeat_pulse  out  N_BTN  1-cycle strobe every REPEAT_CYCLES after long_pulse while held and repeat_en[i]=1
- any_press  out  1  OR of press_pulse, registered in the same cycle as press_pulse

## Operation
- Per channel: norm = btn_in[i] ^ ACTIVE_LOW_MASK[i] feeds sync0 -> sync1. Both flops reset to 0, meaning released.
- Debounce: counter width clog2(DEBOUNCE_CYCLES). If sync1 == level, the counter clears to 0. Otherwise, if counter == DEBOUNCE_CYCLES-1, level <= sync1 and counter <= 0; else counter increments.
- Any single agreeing cycle during a bounce restarts the count; there is no partial credit.
- A level update to 1 sets press_pulse[i] in the same registered update. A level update to 0 sets release_pulse[i]. All pulses are deasserted on every other cycle.
- Hold counter (width clog2(LONG_CYCLES)) clears while level = 0 and counts while level = 1.
- When the hold count reaches LONG_CYCLES-1: long_pulse fires once, the hold counter saturates, and the latched long_done flag is set.
- While long_done = 1, level = 1 and repeat_en[i] = 1: the repeat counter counts 0..REPEAT_CYCLES-1. repeat_pulse fires on each wrap to 0, so the first repeat comes REPEAT_CYCLES cycles after long_pulse.
- If repeat_en[i] = 0, the repeat counter holds at 0. Re-enabling starts a full period.
- Release (level 1->0) clears the hold counter, the repeat counter and long_done in the same cycle release_pulse is generated. A release after a long press still produces release_pulse.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.

## Timing
- Reset values: btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press = 0; all counters and flags = 0.
- Latency: btn_in changes and then stays stable. Count edge 1 as the first rising edge that samples the new value.
  - btn_level and press_pulse/release_pulse become visible after edge DEBOUNCE_CYCLES+2.
  - Each pulse stays high for exactly one cycle.
- long_pulse fires LONG_CYCLES cycles after press_pulse (press_pulse at cycle t, long_pulse at t+LONG_CYCLES).
- repeat_pulse fires at t+LONG_CYCLES+k*REPEAT_CYCLES for k >= 1.
- Glitch rejection: a glitch shorter than DEBOUNCE_CYCLES cycles at sync1 produces no output change.
- Reset asserted mid-debounce or mid-hold: everything clears asynchronously and no pulse is emitted.
  - After deassertion, a held button re-qualifies from zero. It yields a fresh press_pulse after DEBOUNCE_CYCLES+2 edges.
- press_pulse and long_pulse never coincide, because LONG_CYCLES >= 2.
- release_pulse and repeat_pulse never coincide: a release suppresses the repeat for that cycle.

## Test plan
Bench parameters: N_BTN=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW_MASK=4'b1000.
- **Clean press:** btn_in[0] 0->1, held -> btn_level[0] and press_pulse[0] rise after edge 6. press_pulse is 1 cycle wide and any_press pulses in the same cycle.
- **Bounce:** btn_in[1] toggles 1,1,1,0,1,1,1,1 (one sample per cycle) -> no pulse during the toggles. press_pulse[1] comes 4 cycles after the last restart at sync1, exactly once.
- **Long and repeat:** hold btn_in[2] with repeat_en[2]=1 -> long_pulse at press+20, repeat_pulse at press+28, +36, +44. Release -> a single release_pulse[2] and no further repeats. With repeat_en[2]=0 -> long_pulse only.
- **Active-low channel:** btn_in[3] idles at 1 and level stays 0 from reset. Drive it to 0 -> press_pulse[3] after edge 6.
- **Simultaneous channels:** press on channels 0 and 1 in the same cycle -> both press_pulse bits are set in one cycle and any_press is 1 for exactly one cycle.
- **Reset mid-hold:** hold channel 0 for 15 cycles after press, pulse rst_n low -> all outputs 0 immediately. After release of reset with the button still held -> press_pulse[0] after edge 6 and long_pulse 20 cycles after that.

Source files
------------

// File: rtl/multi_button_debounce.sv
// -----------------------------------------------------------------------------
// multi_button_debounce
//
// N-channel front-panel button conditioner. Each channel runs independently:
//   raw pin -> polarity normalisation -> two-flop synchroniser ->
//   integrating debounce filter -> press/release strobes ->
//   long-press detector -> optional auto-repeat generator.
// All outputs are registered and every strobe is exactly one clock wide.
//
// Parameters
//   N_BTN            number of channels (1..16)
//   DEBOUNCE_CYCLES  consecutive disagreeing samples needed to accept a level (>= 2)
//   LONG_CYCLES      accepted-pressed cycles before long_pulse (>= 2)
//   REPEAT_CYCLES    auto-repeat period after the long press (>= 2)
//   ACTIVE_LOW_MASK  bit i set: raw btn_in[i] reads low when pressed
//
// Ports
//   clk            system clock, single domain
//   rst_n          asynchronous active-low reset, clears all state and outputs
//   btn_in         raw asynchronous button pins
//   repeat_en      per-channel auto-repeat enable, sampled every cycle
//   btn_level      debounced level, 1 = pressed (after polarity)
//   press_pulse    one-cycle strobe on an accepted 0->1
//   release_pulse  one-cycle strobe on an accepted 1->0
//   long_pulse     one-cycle strobe once the button has been held LONG_CYCLES
//   repeat_pulse   one-cycle strobe every REPEAT_CYCLES after long_pulse
//   any_press      OR of press_pulse, aligned with press_pulse
// -----------------------------------------------------------------------------
module multi_button_debounce #(
    parameter int unsigned      N_BTN           = 32'd5,
    parameter int unsigned      DEBOUNCE_CYCLES = 32'd1_000_000,
    parameter int unsigned      LONG_CYCLES     = 32'd100_000_000,
    parameter int unsigned      REPEAT_CYCLES   = 32'd20_000_000,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = {N_BTN{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic             any_press
);

    // Counter widths. Each counter only needs to reach (period - 1).
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(LONG_CYCLES);
    localparam int unsigned RW = $clog2(REPEAT_CYCLES);

    localparam logic [DW-1:0] DB_ZERO  = {DW{1'b0}};
    localparam logic [DW-1:0] DB_ONE   = DW'(32'd1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 32'd1);

    localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0] HOLD_ONE  = HW'(32'd1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 32'd1);

    localparam logic [RW-1:0] REP_ZERO = {RW{1'b0}};
    localparam logic [RW-1:0] REP_ONE  = RW'(32'd1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 32'd1);

    // Next-cycle press strobes of all channels, used to build any_press.
    logic [N_BTN-1:0] press_next_s;
    logic             any_press_d;
    logic             any_press_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic          sync0_d;
        logic          sync0_q;
        logic          sync1_d;
        logic          sync1_q;
        logic [DW-1:0] db_cnt_d;
        logic [DW-1:0] db_cnt_q;
        logic          level_d;
        logic          level_q;
        logic          press_d;
        logic          press_q;
        logic          release_d;
        logic          release_q;
        logic [HW-1:0] hold_d;
        logic [HW-1:0] hold_q;
        logic          long_done_d;
        logic          long_done_q;
        logic          long_d;
        logic          long_q;
        logic [RW-1:0] rep_cnt_d;
        logic [RW-1:0] rep_cnt_q;
        logic          rep_d;
        logic          rep_q;

        // Normalise polarity ahead of the synchroniser so everything
        // downstream sees 1 = pressed.
        always_comb begin
            sync0_d = btn_in[i] ^ ACTIVE_LOW_MASK[i];
            sync1_d = sync0_q;
        end

        // Integrating debounce filter: a single agreeing sample wipes the
        // count, so only an unbroken run of DEBOUNCE_CYCLES disagreeing
        // samples moves the accepted level.
        always_comb begin
            db_cnt_d  = db_cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (sync1_q == level_q) begin
                db_cnt_d = DB_ZERO;
            end else if (db_cnt_q == DB_LAST) begin
                db_cnt_d = DB_ZERO;
                level_d  = sync1_q;
                if (sync1_q) begin
                    press_d = 1'b1;
                end else begin
                    release_d = 1'b1;
                end
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end

        // Hold timing, long-press latch and auto-repeat. A release in this
        // cycle takes priority, which also suppresses a coincident repeat.
        always_comb begin
            hold_d      = hold_q;
            long_done_d = long_done_q;
            rep_cnt_d   = rep_cnt_q;
            long_d      = 1'b0;
            rep_d       = 1'b0;
            if (release_d || !level_q) begin
                hold_d      = HOLD_ZERO;
                long_done_d = 1'b0;
                rep_cnt_d   = REP_ZERO;
            end else if (!long_done_q) begin
                // Hold counter saturates at its last value once long fires.
                rep_cnt_d = REP_ZERO;
                if (hold_q == HOLD_LAST) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end else if (repeat_en[i]) begin
                if (rep_cnt_q == REP_LAST) begin
                    rep_cnt_d = REP_ZERO;
                    rep_d     = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_ONE;
                end
            end else begin
                // Disabled: park at zero so re-enabling gives a full period.
                rep_cnt_d = REP_ZERO;
            end
        end

        // Channel state and output registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync0_q     <= 1'b0;
                sync1_q     <= 1'b0;
                db_cnt_q    <= DB_ZERO;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                hold_q      <= HOLD_ZERO;
                long_done_q <= 1'b0;
                long_q      <= 1'b0;
                rep_cnt_q   <= REP_ZERO;
                rep_q       <= 1'b0;
            end else begin
                sync0_q     <= sync0_d;
                sync1_q     <= sync1_d;
                db_cnt_q    <= db_cnt_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                hold_q      <= hold_d;
                long_done_q <= long_done_d;
                long_q      <= long_d;
                rep_cnt_q   <= rep_cnt_d;
                rep_q       <= rep_d;
            end
        end

        assign btn_level[i]     = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
        assign repeat_pulse[i]  = rep_q;
        assign press_next_s[i]  = press_d;
    end

    // any_press is built from next-state strobes so it lands in the same
    // cycle as the press_pulse bits rather than one cycle later.
    always_comb begin
        any_press_d = |press_next_s;
    end

    // any_press output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;

endmodule
